// File: rtl/line_clear_ctrl.sv
// Sequential line-clear engine: scans a locked playfield from bottom row to top,
// drops every full row out, and reports the compacted field, line count and score.
module line_clear_ctrl #(
  parameter int ROWS = 20,
  parameter int COLS = 20,
  parameter int LW   = 5
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [0:ROWS*COLS-1]   field_in,
  output logic                   busy,
  output logic                   done,
  output logic [0:ROWS*COLS-1]   field_out,
  output logic [LW-1:0]          lines_cleared,
  output logic [3:0]             score_delta
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [LW-1:0] PTR_TOP = LW'(ROWS - 1);
  localparam logic [LW-1:0] CNT_MAX = '1;

  state_t          state, state_nx;
  logic [COLS-1:0] rows_q [ROWS];
  logic [LW-1:0]   ptr_q;
  logic [LW-1:0]   line_cnt_q;
  logic            row_full;
  logic            scan_last;

  // Score awarded for a single operation, keyed on the number of rows removed.
  function automatic logic [3:0] score_of(input logic [LW-1:0] n);
    logic [3:0] s;
    case (n)
      LW'(0):  s = 4'd0;
      LW'(1):  s = 4'd1;
      LW'(2):  s = 4'd3;
      LW'(3):  s = 4'd5;
      default: s = 4'd8;
    endcase
    return s;
  endfunction

  assign row_full  = &rows_q[ptr_q];
  assign scan_last = (ptr_q == '0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    // NOTE: default assigned first so every path writes state_nx; no latch inferred.
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SCAN;
      SCAN: begin
        if (row_full)       state_nx = SHIFT;
        else if (scan_last) state_nx = DONE;
      end
      SHIFT:   state_nx = SCAN;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == SCAN) || (state == SHIFT);
  assign done = (state == DONE);

  // Field register, row pointer, line counter and the held results.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the field is a small flop array, not a RAM, so it is reset to an empty board.
      for (int r = 0; r < ROWS; r++) rows_q[r] <= '0;
      ptr_q         <= PTR_TOP;
      line_cnt_q    <= '0;
      lines_cleared <= '0;
      score_delta   <= '0;
    end else begin
      // NOTE: all state here updates with non-blocking assignments so SHIFT reads old rows.
      unique case (state)
        IDLE: begin
          if (start) begin
            for (int r = 0; r < ROWS; r++) rows_q[r] <= field_in[r*COLS +: COLS];
            ptr_q      <= PTR_TOP;
            line_cnt_q <= '0;
          end
        end
        SCAN: begin
          if (!row_full) begin
            if (!scan_last) begin
              ptr_q <= ptr_q - LW'(1);
            end else begin
              lines_cleared <= line_cnt_q;
              score_delta   <= score_of(line_cnt_q);
            end
          end
        end
        SHIFT: begin
          // Rows 1..ptr drop by one; an empty row enters at the top.
          for (int j = 1; j < ROWS; j++) begin
            if (LW'(j) <= ptr_q) rows_q[j] <= rows_q[j-1];
          end
          rows_q[0] <= '0;
          if (line_cnt_q != CNT_MAX) line_cnt_q <= line_cnt_q + LW'(1);
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_pack
    assign field_out[r*COLS +: COLS] = rows_q[r];
  end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Self-checking bench for line_clear_ctrl: directed scenarios plus randomized fields
// checked against a row-filtering reference model.
module tb_line_clear_ctrl;

  localparam int ROWS = 20;
  localparam int COLS = 20;
  localparam int LW   = 5;
  localparam int N    = ROWS * COLS;
  localparam int MAX_WAIT = 200;

  typedef logic [0:N-1] field_t;

  logic            clock = 1'b0;
  logic            resetn = 1'b0;
  logic            start = 1'b0;
  field_t          field_in = '0;
  logic            busy;
  logic            done;
  field_t          field_out;
  logic [LW-1:0]   lines_cleared;
  logic [3:0]      score_delta;

  int checks = 0;
  int errors = 0;

  line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .LW(LW)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .start        (start),
    .field_in     (field_in),
    .busy         (busy),
    .done         (done),
    .field_out    (field_out),
    .lines_cleared(lines_cleared),
    .score_delta  (score_delta)
  );

  always #5 clock = ~clock;

  function automatic field_t set_row(input field_t f, input int r, input logic [COLS-1:0] v);
    field_t g;
    g = f;
    g[r*COLS +: COLS] = v;
    return g;
  endfunction

  // Reference: a clear keeps the non-full rows in their bottom-to-top order and pads the top with empty rows.
  function automatic void model(input field_t f, output field_t res, output int l);
    logic [COLS-1:0] kept[$];
    logic [COLS-1:0] row;
    l = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      row = f[r*COLS +: COLS];
      if (row == '1) l++;
      else kept.push_back(row);
    end
    res = '0;
    for (int k = 0; k < kept.size(); k++) res[(ROWS-1-k)*COLS +: COLS] = kept[k];
  endfunction

  function automatic int score_ref(input int l);
    int tbl[5] = '{0, 1, 3, 5, 8};
    return tbl[(l > 4) ? 4 : l];
  endfunction

  // Runs one operation; optionally re-pulses start with alt_field at cycle restart_at.
  task automatic run_op(input string name, input field_t f, input int restart_at, input field_t alt_field);
    field_t exp_f;
    int     exp_l, exp_lat, lat, bcnt;
    bit     got;
    model(f, exp_f, exp_l);
    exp_lat = ROWS + 2 * exp_l;
    @(negedge clock);
    field_in = f;
    start    = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    lat = 0; bcnt = 0; got = 1'b0;
    while (lat < MAX_WAIT) begin
      if (busy) bcnt++;
      @(posedge clock);
      lat++;
      @(negedge clock);
      start = 1'b0;
      if (done) begin got = 1'b1; break; end
      if (lat == restart_at) begin
        start    = 1'b1;
        field_in = alt_field;
      end
    end
    start = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s done_timeout: no done within %0d cycles", name, MAX_WAIT);
    end
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (bcnt != exp_lat) begin
      errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, bcnt, exp_lat);
    end
    checks++;
    if (field_out !== exp_f) begin
      errors++; $display("FAIL %s field_out: got %h expected %h", name, field_out, exp_f);
    end
    checks++;
    if (lines_cleared !== LW'(exp_l)) begin
      errors++; $display("FAIL %s lines_cleared: got %0d expected %0d", name, lines_cleared, exp_l);
    end
    checks++;
    if (score_delta !== 4'(score_ref(exp_l))) begin
      errors++; $display("FAIL %s score_delta: got %0d expected %0d", name, score_delta, score_ref(exp_l));
    end
    @(negedge clock);
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++; $display("FAIL %s done_pulse_width: got done=%b busy=%b expected 0 0", name, done, busy);
    end
    checks++;
    if (field_out !== exp_f || lines_cleared !== LW'(exp_l)) begin
      errors++; $display("FAIL %s idle_hold: got lines=%0d field=%h expected lines=%0d field=%h",
                         name, lines_cleared, field_out, exp_l, exp_f);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done} !== 2'b00 || field_out !== '0 || lines_cleared !== '0 || score_delta !== '0) begin
      errors++;
      $display("FAIL reset_values: got busy=%b done=%b lines=%0d score=%0d field=%h expected all zero",
               busy, done, lines_cleared, score_delta, field_out);
    end
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_empty();
    run_op("empty", '0, -1, '0);
  endtask

  task automatic test_single();
    field_t f = '0;
    f = set_row(f, 19, '1);
    f = set_row(f, 18, 20'h00001);
    run_op("single", f, -1, '0);
  endtask

  function automatic field_t four_full();
    field_t f = '0;
    for (int r = 16; r < ROWS; r++) f = set_row(f, r, '1);
    return f;
  endfunction

  task automatic test_four();
    run_op("four", four_full(), -1, '0);
  endtask

  task automatic test_alternating();
    field_t f = '0;
    f = set_row(f, 19, '1);
    f = set_row(f, 17, '1);
    f = set_row(f, 18, 20'hAAAAA);
    f = set_row(f, 16, 20'h55555);
    run_op("alternating", f, -1, '0);
  endtask

  task automatic test_start_while_busy();
    field_t f = '0;
    f = set_row(f, 19, '1);
    f = set_row(f, 10, 20'h12345);
    run_op("start_busy", f, 5, {N{1'b1}});
  endtask

  task automatic test_start_in_done();
    int lat = 0;
    @(negedge clock);
    field_in = '0;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    while (!done && lat < MAX_WAIT) begin
      @(negedge clock);
      lat++;
    end
    start    = 1'b1;
    field_in = {N{1'b1}};
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || field_out !== '0) begin
      errors++; $display("FAIL start_in_done: got busy=%b field=%h expected busy=0 field=0", busy, field_out);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL start_in_done_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    int lat = 0;
    bit saw_done = 1'b0;
    @(negedge clock);
    field_in = four_full();
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    while (lat < 7) begin
      @(negedge clock);
      lat++;
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({busy, done} !== 2'b00 || field_out !== '0 || lines_cleared !== '0 || score_delta !== '0) begin
      errors++;
      $display("FAIL reset_mid_values: got busy=%b done=%b lines=%0d score=%0d expected all zero",
               busy, done, lines_cleared, score_delta);
    end
    repeat (30) begin
      @(negedge clock);
      if (done) saw_done = 1'b1;
      if (lat == 9) resetn = 1'b1;
      lat++;
    end
    checks++;
    if (saw_done) begin
      errors++; $display("FAIL reset_mid_no_done: got done pulse expected none");
    end
    run_op("after_reset", four_full(), -1, '0);
  endtask

  task automatic test_random();
    field_t f;
    for (int it = 0; it < 25; it++) begin
      f = '0;
      for (int r = 0; r < ROWS; r++) begin
        if ($urandom_range(2) == 0) f = set_row(f, r, '1);
        else                        f = set_row(f, r, COLS'($urandom));
      end
      run_op("random", f, -1, '0);
    end
    run_op("all_ones", {N{1'b1}}, -1, '0);
  endtask

  initial begin
    test_reset();
    test_empty();
    test_single();
    test_four();
    test_alternating();
    test_start_while_busy();
    test_start_in_done();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
